// File: rtl/ram_burst_reader_pkg.sv
// Shared state encoding and default widths for the RAM burst read path.
package ram_burst_reader_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_burst_reader_if.sv
// Control, RAM read port and output stream of the burst reader.
interface ram_burst_reader_if
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  start, base_addr, len, ram_rd_data, out_ready,
        output busy, done, ram_rd_en, ram_rd_addr, out_data, out_valid
    );

    modport slave (
        output start, base_addr, len, ram_rd_data, out_ready,
        input  busy, done, ram_rd_en, ram_rd_addr, out_data, out_valid
    );
endinterface

// File: rtl/ram_rd_fifo2.sv
// Two-entry synchronous FIFO holding RAM words until the stream accepts them.
// The caller must not push while full unless it pops in the same cycle.
module ram_rd_fifo2 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != 2'd0);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master: issues len RAM reads from base_addr and streams the words
// out on valid/ready, never keeping more than two words outstanding.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic               clk,
    input logic               rst,
    ram_burst_reader_if.master bus
);
    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  accepted_q, accepted_d;
    logic                  inflight_q, inflight_d;

    logic [1:0]            fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  pop_c;
    logic                  push_c;
    logic                  rd_en_c;
    logic [2:0]            occ_c;

    ram_rd_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (bus.ram_rd_data),
        .count     (fifo_count),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state, read issue and beat accounting.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        pop_c      = !fifo_empty && bus.out_ready;
        push_c     = inflight_q && (!fifo_full || pop_c);
        // Words buffered plus in flight, counting a beat leaving this cycle as gone.
        occ_c      = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);
        rd_en_c    = (state_q == READ) && (occ_c < 3'd2);
        inflight_d = rd_en_c;
        if (pop_c) begin
            accepted_d = accepted_q + LEN_WIDTH'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    len_d      = bus.len;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = (bus.len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (rd_en_c) begin
                    issued_d = issued_q + LEN_WIDTH'(1);
                    if (issued_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accepted_d == len_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
        end
    end

    // Address wraps naturally at 2**ADDR_WIDTH.
    assign bus.ram_rd_en   = rd_en_c;
    assign bus.ram_rd_addr = base_q + ADDR_WIDTH'(issued_q);
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = fifo_head;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a 1-cycle-latency RAM model.
module tb_ram_burst_reader;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_burst_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end

    typedef struct {
        logic [3:0] base;
        logic [4:0] len;
        int         mode;          // 0: ready high, 1: stall then toggle, 2: random
        bit         mid_start;
        int         exp_first_en;  // cycle after start edge, -1 = never
        int         exp_first_val;
        int         exp_done;      // -1 = one cycle after last beat
    } vec_t;

    vec_t vecs[6];

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] beats[$];
    logic [3:0] addrs[$];
    int first_en, first_val, done_cyc, done_cnt, last_beat;
    int viol_out, viol_stab, busy_gap, busy_after, outstanding;
    bit prev_stall;
    logic [7:0] prev_data;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return (k >= 3 && k <= 8) ? 1'b0 : ((k % 2) == 1);
            2:       return ($urandom_range(0, 1) == 1);
            default: return 1'b1;
        endcase
    endfunction

    task automatic sample_cycle(input int k);
        logic pop;
        pop = bus.out_valid && bus.out_ready;
        if (bus.ram_rd_en) begin
            if (outstanding - int'(pop) >= 2) viol_out++;
            addrs.push_back(bus.ram_rd_addr);
            if (first_en < 0) first_en = k;
        end
        if (bus.out_valid && first_val < 0) first_val = k;
        if (prev_stall && (!bus.out_valid || bus.out_data != prev_data)) viol_stab++;
        if (pop) begin
            beats.push_back(bus.out_data);
            last_beat = k;
        end
        if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
        end else if (done_cyc < 0 && !bus.busy) begin
            busy_gap++;
        end
        if (done_cyc >= 0 && k == done_cyc + 1) busy_after = int'(bus.busy);
        outstanding += int'(bus.ram_rd_en) - int'(pop);
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
    endtask

    task automatic run_burst(input logic [3:0] b, input logic [4:0] l, input int mode,
                             input bit mid, input int max_cyc);
        beats.delete();
        addrs.delete();
        first_en = -1; first_val = -1; done_cyc = -1; done_cnt = 0; last_beat = -1;
        viol_out = 0; viol_stab = 0; busy_gap = 0; busy_after = -1; outstanding = 0;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = b; bus.len = l; bus.out_ready = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            bus.start = mid && (k == 5);
            if (mid && k == 5) begin
                bus.base_addr = 4'd9;
                bus.len       = 5'd3;
            end
            bus.out_ready = ready_for(mode, k);
            #1;
            sample_cycle(k);
            if (done_cyc >= 0 && k >= done_cyc + 1) break;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic check_common(input string tag, input logic [3:0] b, input logic [4:0] l);
        int bad_d, bad_a;
        logic [7:0] e;
        bad_d = 0;
        bad_a = 0;
        chk({tag, ".beats"}, beats.size(), int'(l));
        for (int i = 0; i < beats.size(); i++) begin
            e = 8'hA0 + 8'((int'(b) + i) % 16);
            if (beats[i] != e) bad_d++;
        end
        chk({tag, ".bad_data"}, bad_d, 0);
        chk({tag, ".reads"}, addrs.size(), int'(l));
        for (int i = 0; i < addrs.size(); i++) begin
            if (addrs[i] != 4'((int'(b) + i) % 16)) bad_a++;
        end
        chk({tag, ".bad_addr"}, bad_a, 0);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".outstanding_viol"}, viol_out, 0);
        chk({tag, ".stall_unstable"}, viol_stab, 0);
        chk({tag, ".busy_gap"}, busy_gap, 0);
        chk({tag, ".busy_after"}, busy_after, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, int'(bus.busy), 0);
        chk({tag, ".done"}, int'(bus.done), 0);
        chk({tag, ".rd_en"}, int'(bus.ram_rd_en), 0);
        chk({tag, ".rd_addr"}, int'(bus.ram_rd_addr), 0);
        chk({tag, ".out_data"}, int'(bus.out_data), 0);
        chk({tag, ".out_valid"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int nb;
        string tag;
        vecs[0] = '{4'd0,  5'd8,  0, 1'b0,  1,  3, 11};
        vecs[1] = '{4'd14, 5'd4,  0, 1'b0,  1,  3,  7};
        vecs[2] = '{4'd0,  5'd8,  1, 1'b0,  1,  3, -1};
        vecs[3] = '{4'd0,  5'd0,  0, 1'b0, -1, -1,  1};
        vecs[4] = '{4'd0,  5'd16, 0, 1'b1,  1,  3, 19};
        vecs[5] = '{4'd5,  5'd16, 2, 1'b0,  1,  3, -1};
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        bus.ram_rd_data = '0;
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tag = $sformatf("v%0d", i);
            run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].mid_start, 200);
            check_common(tag, vecs[i].base, vecs[i].len);
            chk({tag, ".first_rd_en"}, first_en, vecs[i].exp_first_en);
            chk({tag, ".first_valid"}, first_val, vecs[i].exp_first_val);
            if (vecs[i].exp_done >= 0)
                chk({tag, ".done_cycle"}, done_cyc, vecs[i].exp_done);
            else
                chk({tag, ".done_after_last"}, done_cyc, last_beat + 1);
        end

        // Reset during the third beat of a burst aborts it without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 4'd0; bus.len = 5'd8; bus.out_ready = 1'b1;
        nb = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) nb++;
            if (nb == 3) break;
        end
        chk("abort.reached_beat3", nb, 3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_zero("abort");
        rst = 1'b0;
        nb = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy || bus.out_valid) nb++;
        end
        chk("abort.quiet_after", nb, 0);

        run_burst(4'd2, 5'd3, 0, 1'b0, 60);
        check_common("post_abort", 4'd2, 5'd3);
        chk("post_abort.done_cycle", done_cyc, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side master for the dual-port RAM. Software or a controller issues one start with a base address and length.
- The block drives the RAM read port (rd_en / rd_addr) and absorbs the RAM's 1-cycle read latency.
- It streams the words out on a valid/ready interface with full backpressure support.
- It is the consumer counterpart to the RAM write path and sits between the RAM read port and downstream logic.

Parameters:
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.

Ports:
- clk  in  1  single clock. RAM read port and all logic use it.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first read address; captured on accepted start.
- len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; captured on accepted start.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse at burst completion.
- ram_rd_en  out  1  RAM read strobe.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid the cycle after ram_rd_en.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a beat transfers when out_valid && out_ready.

Behaviour:
- Reset: rst high at a clk edge sets all outputs to 0 the next cycle (busy, done, ram_rd_en, ram_rd_addr, out_data, out_valid).
  - State goes to IDLE, the FIFO empties, the in-flight flag clears and any in-flight RAM data is discarded.
  - A reset mid-burst aborts the burst with no done pulse.
- States:
  - IDLE -> READ on start when len != 0.
  - IDLE -> DONE on start when len == 0.
  - READ -> DRAIN after the last read is issued.
  - DRAIN -> DONE after the last beat is accepted.
  - DONE -> IDLE unconditionally after one cycle.
- Start handling: start is accepted only in IDLE; start in any other state is ignored. base_addr and len are registered on acceptance.
- busy: high in READ, DRAIN and DONE; low in IDLE.
- done: high only in DONE.
  - For len = 0, done is high in cycle N+1 (start at edge N) and no ram_rd_en is ever asserted.
- Read issue:
  - ram_rd_en is high in READ when fifo_count + inflight - pop < 2 (pop = out_valid && out_ready this cycle).
  - ram_rd_addr = base_addr + issued_count, modulo 2**ADDR_WIDTH, so reads wrap from 2**ADDR_WIDTH-1 to 0.
  - issued_count increments on each issued read; READ ends when issued_count == len.
- Latency and capture:
  - The inflight flag is set the cycle after ram_rd_en. While it is set, ram_rd_data is pushed into a 2-entry FIFO at that cycle's edge.
  - out_valid/out_data come from the FIFO head (registered).
  - With out_ready held high: first ram_rd_en in N+1, first out_valid in N+3, then one beat per cycle with no bubbles.
- Backpressure:
  - While out_valid && !out_ready, out_data must hold stable.
  - At most 2 words may be outstanding (buffered + in flight), so the FIFO never overflows and no word is dropped or duplicated.
  - Simultaneous push and pop in one cycle leaves the count unchanged.
- Ordering: beats are delivered in address order, exactly len beats per burst.
- Completion: DRAIN exits when accepted_count == len. done pulses the cycle after the final handshake.

Decomposition:
- Shared package:
  - State enum: IDLE, READ, DRAIN, DONE.
  - Default ADDR_WIDTH / DATA_WIDTH constants, shared with the RAM.
- One sub-module: ram_rd_fifo2, a 2-entry synchronous FIFO.
  - Signals: push, pop, count, head data, full, empty.
  - Reset behaviour: sync reset to empty.

Test Plan:
- Bench RAM model with 1-cycle read latency, preloaded mem[i] = 8'hA0 + i.
- Directed scenarios:
  1. base 0, len 8, out_ready=1 -> ram_rd_en in N+1..N+8, addresses 0..7, out_data A0..A7 on consecutive cycles starting N+3, done pulse exactly one cycle after the A7 beat, busy low after.
  2. base 14, len 4 -> ram_rd_addr 14,15,0,1; beats AE,AF,A0,A1.
  3. base 0, len 8, out_ready low for cycles N+3..N+8 then toggling -> A0..A7 each delivered exactly once in order; out_data stable while stalled; ram_rd_en never asserted with 2 words outstanding.
  4. len 0 -> done high in N+1 only; ram_rd_en and out_valid never assert.
  5. start pulsed during a READ of len 16 -> ignored, exactly 16 beats A0..AF. Then rst during a second burst's 3rd beat -> all outputs 0 next cycle, no done; a following burst base 2 len 3 yields A2,A3,A4.
  6. len 16 from base 5 with random out_ready -> 16 beats A5..AF, A0..A4; done once; no FIFO overflow.
